fft_out_serializer: RTL and testbench

Output-side reader for the 8-point FFT pipeline. It captures one parallel frame of last-stage results (y0, y4 real-only; y1–y3, y5–y7 complex) on a valid/ready handshake and streams the frame out as 8 complex beats with a valid/ready handshake. Two frame buffers (ping-pong) let a new frame be captured while the previous one drains. It sits directly after the final FFT butterfly stage and feeds downstream sample consumers.

---
 rtl/fft_out_serializer.sv | 121 ++++++++++++
 tb/tb_fft_out_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_serializer.sv
// Ping-pong frame buffer: captures one 8-bin FFT frame, streams it as 8 complex beats; BITREV_ORDER_EN selects bit-reversed beat order.
// Latency: beat 0 valid the cycle after capture; in_ready drops when both banks are occupied, outputs hold while out_ready is low.
module fft_out_serializer #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2**N-1:0]   y0,
    input  logic [2**N-1:0]   y4,
    input  logic [2**N-1:0]   yr1,
    input  logic [2**N-1:0]   yi1,
    input  logic [2**N-1:0]   yr2,
    input  logic [2**N-1:0]   yi2,
    input  logic [2**N-1:0]   yr3,
    input  logic [2**N-1:0]   yi3,
    input  logic [2**N-1:0]   yr5,
    input  logic [2**N-1:0]   yi5,
    input  logic [2**N-1:0]   yr6,
    input  logic [2**N-1:0]   yi6,
    input  logic [2**N-1:0]   yr7,
    input  logic [2**N-1:0]   yi7,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2**N-1:0]   out_re,
    output logic [2**N-1:0]   out_im,
    output logic [2:0]        out_idx,
    output logic              out_last,
    output logic              ovf
);
    localparam int W = 2**N;

    logic [W-1:0] re_mem_q [2][8];
    logic [W-1:0] im_mem_q [2][8];

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] occ_q, occ_d;
    logic [2:0] beat_q, beat_d;
    logic       ovf_q, ovf_d;

    logic       capture;
    logic       advance;
    logic       release_frame;
    logic [2:0] rd_idx;

    assign in_ready      = (occ_q != 2'd2);
    assign out_valid     = (occ_q != 2'd0);
    assign capture       = in_valid && in_ready;
    assign advance       = out_valid && out_ready;
    assign release_frame = advance && (beat_q == 3'd7);

`ifdef BITREV_ORDER_EN
    assign rd_idx = {beat_q[0], beat_q[1], beat_q[2]};
`else
    assign rd_idx = beat_q;
`endif

    // Bank storage is deliberately not reset; occ gates whether it is ever read.
    always_ff @(posedge clk) begin
        if (capture) begin
            re_mem_q[wr_bank_q][0] <= y0;   im_mem_q[wr_bank_q][0] <= '0;
            re_mem_q[wr_bank_q][1] <= yr1;  im_mem_q[wr_bank_q][1] <= yi1;
            re_mem_q[wr_bank_q][2] <= yr2;  im_mem_q[wr_bank_q][2] <= yi2;
            re_mem_q[wr_bank_q][3] <= yr3;  im_mem_q[wr_bank_q][3] <= yi3;
            re_mem_q[wr_bank_q][4] <= y4;   im_mem_q[wr_bank_q][4] <= '0;
            re_mem_q[wr_bank_q][5] <= yr5;  im_mem_q[wr_bank_q][5] <= yi5;
            re_mem_q[wr_bank_q][6] <= yr6;  im_mem_q[wr_bank_q][6] <= yi6;
            re_mem_q[wr_bank_q][7] <= yr7;  im_mem_q[wr_bank_q][7] <= yi7;
        end
    end

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        occ_d     = occ_q;
        beat_d    = beat_q;
        ovf_d     = ovf_q;
        if (capture) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (advance) begin
            beat_d = beat_q + 3'd1;
        end
        if (release_frame) begin
            rd_bank_d = ~rd_bank_q;
        end
        case ({capture, release_frame})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        if (in_valid && !in_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            occ_q     <= 2'd0;
            beat_q    <= 3'd0;
            ovf_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            occ_q     <= occ_d;
            beat_q    <= beat_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_re   = out_valid ? re_mem_q[rd_bank_q][rd_idx] : '0;
    assign out_im   = out_valid ? im_mem_q[rd_bank_q][rd_idx] : '0;
    assign out_idx  = out_valid ? rd_idx : 3'd0;
    assign out_last = out_valid && (beat_q == 3'd7);
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Randomized bench for fft_out_serializer: frame-queue reference model plus directed literal checks.
module tb_fft_out_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] y0 = '0, y4 = '0;
    logic [15:0] yr1 = '0, yi1 = '0, yr2 = '0, yi2 = '0, yr3 = '0, yi3 = '0;
    logic [15:0] yr5 = '0, yi5 = '0, yr6 = '0, yi6 = '0, yr7 = '0, yi7 = '0;
    logic        in_ready, out_valid, out_last, ovf;
    logic [15:0] out_re, out_im;
    logic [2:0]  out_idx;

    fft_out_serializer #(.N(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y4(y4),
        .yr1(yr1), .yi1(yi1), .yr2(yr2), .yi2(yi2), .yr3(yr3), .yi3(yi3),
        .yr5(yr5), .yi5(yi5), .yr6(yr6), .yi6(yi6), .yr7(yr7), .yi7(yi7),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
        .out_last(out_last), .ovf(ovf)
    );

    always #5 clk = ~clk;

`ifdef BITREV_ORDER_EN
    localparam int ORD [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    localparam int ORD [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

    typedef struct packed {
        logic [7:0][15:0] re;
        logic [7:0][15:0] im;
    } frame_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input frame_t f);
        y0  = f.re[0]; y4  = f.re[4];
        yr1 = f.re[1]; yi1 = f.im[1];
        yr2 = f.re[2]; yi2 = f.im[2];
        yr3 = f.re[3]; yi3 = f.im[3];
        yr5 = f.re[5]; yi5 = f.im[5];
        yr6 = f.re[6]; yi6 = f.im[6];
        yr7 = f.re[7]; yi7 = f.im[7];
    endtask

    function automatic frame_t rnd_frame();
        frame_t f;
        for (int i = 0; i < 8; i++) begin
            f.re[i] = 16'($urandom);
            f.im[i] = (i == 0 || i == 4) ? 16'h0 : 16'($urandom);
        end
        return f;
    endfunction

    function automatic frame_t sample_in();
        frame_t f;
        f.re[0] = y0;  f.im[0] = 16'h0;
        f.re[1] = yr1; f.im[1] = yi1;
        f.re[2] = yr2; f.im[2] = yi2;
        f.re[3] = yr3; f.im[3] = yi3;
        f.re[4] = y4;  f.im[4] = 16'h0;
        f.re[5] = yr5; f.im[5] = yi5;
        f.re[6] = yr6; f.im[6] = yi6;
        f.re[7] = yr7; f.im[7] = yi7;
        return f;
    endfunction

    // Reference: a queue of at most two stored frames and a position within the head frame.
    frame_t mq[$];
    int     mbeat = 0;
    bit     movf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mbeat = 0;
            movf = 1'b0;
        end else begin
            bit cap, adv;
            frame_t nf;
            nf  = sample_in();
            cap = in_valid && (mq.size() < 2);
            adv = (mq.size() != 0) && out_ready;
            if (in_valid && mq.size() == 2) movf = 1'b1;
            if (adv) begin
                if (mbeat == 7) begin
                    void'(mq.pop_front());
                    mbeat = 0;
                end else begin
                    mbeat = mbeat + 1;
                end
            end
            if (cap) mq.push_back(nf);
        end
    end

    logic        pv = 1'b0, pr = 1'b0, plast = 1'b0;
    logic [15:0] pre = '0, pim = '0;
    logic [2:0]  pidx = '0;

    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            chk("in_ready", in_ready, mq.size() != 2);
            chk("out_valid", out_valid, mq.size() != 0);
            chk("ovf", ovf, movf);
            if (mq.size() != 0) begin
                int bin;
                bin = ORD[mbeat];
                chk("out_idx", out_idx, bin);
                chk("out_re", out_re, mq[0].re[bin]);
                chk("out_im", out_im, mq[0].im[bin]);
                chk("out_last", out_last, mbeat == 7);
            end else begin
                chk("idle_re", out_re, 0);
                chk("idle_im", out_im, 0);
                chk("idle_idx", out_idx, 0);
                chk("idle_last", out_last, 0);
            end
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", {out_idx, out_last, out_re}, {pidx, plast, pre});
                chk("hold_im", out_im, pim);
            end
            pv = out_valid; pr = out_ready; pre = out_re; pim = out_im;
            pidx = out_idx; plast = out_last;
        end
    end

    initial begin
        frame_t f1, fa, fr;
        bit found;

        // Reset state
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Known frame, literal expectations
        for (int i = 0; i < 8; i++) begin
            f1.re[i] = 16'(i);
            f1.im[i] = (i == 0 || i == 4) ? 16'h0 : 16'(-i);
        end
        f1.re[0] = 16'h0010;
        f1.re[4] = 16'h0040;
        @(negedge clk);
        drive(f1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            int b;
            logic [15:0] er, ei;
            b  = ORD[k];
            er = (b == 0) ? 16'h0010 : (b == 4) ? 16'h0040 : 16'(b);
            ei = (b == 0 || b == 4) ? 16'h0 : 16'(-b);
            chk("t1_valid", out_valid, 1);
            chk("t1_idx", out_idx, b);
            chk("t1_re", out_re, er);
            chk("t1_im", out_im, ei);
            chk("t1_last", out_last, k == 7);
            @(negedge clk);
        end
        chk("t1_done", out_valid, 0);
        chk("t1_beat0_idx", 32'(ORD[0]), 0);

        // Backpressure on beat 2
        drive(rnd_frame());
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_hold_idx", out_idx, ORD[2]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_idx", out_idx, ORD[3]);
        repeat (8) @(negedge clk);

        // Full / overflow
        out_ready = 1'b0;
        fa = rnd_frame();
        drive(fa);
        in_valid = 1'b1;
        @(negedge clk);
        drive(rnd_frame());
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        drive(rnd_frame());
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_set", ovf, 1);
        chk("full_head_re", out_re, fa.re[0]);
        out_ready = 1'b1;
        repeat (17) @(negedge clk);
        chk("ovf_sticky", ovf, 1);
        chk("drained", out_valid, 0);

        // Release of beat 7 coinciding with in_valid while full
        out_ready = 1'b0;
        drive(rnd_frame());
        in_valid = 1'b1;
        @(negedge clk);
        drive(rnd_frame());
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (out_last) found = 1'b1;
        end
        chk("sim_found_last", found, 1);
        chk("sim_ready_0", in_ready, 0);
        drive(rnd_frame());
        in_valid = 1'b1;
        @(negedge clk);
        chk("sim_ready_1", in_ready, 1);
        @(negedge clk);
        chk("sim_ready_2", in_ready, 0);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            drive(rnd_frame());
            in_valid = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Reset mid-frame at beat 5
        drive(rnd_frame());
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (mq.size() != 0 && mbeat == 5) found = 1'b1;
            else @(negedge clk);
        end
        chk("mid_found_beat5", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_re", out_re, 0);
        chk("mid_im", out_im, 0);
        chk("mid_idx", out_idx, 0);
        chk("mid_last", out_last, 0);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        fr = rnd_frame();
        drive(fr);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_idx", out_idx, 0);
        chk("post_rst_re", out_re, fr.re[0]);
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
